writeback_regfile: RTL and testbench

- Writeback-stage consumer of the MEM/WB pipeline register outputs in the pipelined RV64 core.
- Selects the writeback value between the execution result and the data-memory result.
- Commits that value to the 32x64 integer register file and serves the two ID-stage read ports, with same-cycle write-through bypass.
- Maintains the retired-instruction counter (instret) for the CSR unit.

---
 rtl/rv64_pkg.sv | 7 +
 rtl/regfile_bank.sv | 34 +++
 rtl/writeback_regfile.sv | 65 ++++++
 tb/tb_writeback_regfile.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/rv64_pkg.sv
// rtl/rv64_pkg.sv - shared widths and constants for the RV64 writeback stage
package rv64_pkg;
  localparam int XLEN = 64;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;
  localparam int INSTRET_W = 64;
endpackage

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - integer register array, one sync write port, two async read ports
module regfile_bank
  import rv64_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [XLEN-1:0] rdata_a,
  output logic [XLEN-1:0] rdata_b
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (waddr != AW'(REG_X0))) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 reads as zero regardless of what the array slot holds
  assign rdata_a = (raddr_a == AW'(REG_X0)) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == AW'(REG_X0)) ? '0 : regs[raddr_b];

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - WB mux, register file commit with write-through bypass, instret
module writeback_regfile
  import rv64_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] wrd,
  input  logic [XLEN-1:0]       wr,
  input  logic [XLEN-1:0]       wd,
  input  logic                  wm2reg,
  input  logic                  wwreg,
  input  logic                  wvalid,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]       qa,
  output logic [XLEN-1:0]       qb,
  output logic [XLEN-1:0]       wbdata,
  output logic [INSTRET_W-1:0]  instret
);

  logic                 we;
  logic                 commit;
  logic [XLEN-1:0]      bank_a;
  logic [XLEN-1:0]      bank_b;
  logic [INSTRET_W-1:0] instret_q;

  assign wbdata = wm2reg ? wd : wr;
  assign we     = wwreg & wvalid & (wrd != REG_X0);
  // a write squashed by reset must not be forwarded either
  assign commit = we & ~rst;

  regfile_bank #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (REG_ADDR_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (commit),
    .waddr   (wrd),
    .wdata   (wbdata),
    .raddr_a (rs1),
    .raddr_b (rs2),
    .rdata_a (bank_a),
    .rdata_b (bank_b)
  );

  // commit already excludes wrd==x0, so a matching rs can never be x0 here
  assign qa = (commit && (rs1 == wrd)) ? wbdata : bank_a;
  assign qb = (commit && (rs2 == wrd)) ? wbdata : bank_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (wvalid) begin
      instret_q <= instret_q + INSTRET_W'(1);
    end
  end

  assign instret = instret_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - scoreboard bench with randomized stimulus and reference model
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wrd, rs1, rs2;
  logic [63:0] wr, wd;
  logic        wm2reg, wwreg, wvalid;
  logic [63:0] qa, qb, wbdata, instret;

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk     (clk),
    .rst     (rst),
    .wrd     (wrd),
    .wr      (wr),
    .wd      (wd),
    .wm2reg  (wm2reg),
    .wwreg   (wwreg),
    .wvalid  (wvalid),
    .rs1     (rs1),
    .rs2     (rs2),
    .qa      (qa),
    .qb      (qb),
    .wbdata  (wbdata),
    .instret (instret)
  );

  typedef struct {
    string       tag;
    logic [63:0] qa;
    logic [63:0] qb;
    logic [63:0] wbdata;
    logic [63:0] instret;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] mdl_regs [32];
  logic [63:0] mdl_instret;
  int          total = 0;
  int          passed = 0;
  bit          stim_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // one WB cycle: drive after posedge, predict visible outputs, then advance the model
  task automatic step(input bit r, input logic [4:0] a_wrd, input logic [63:0] a_wr,
                      input logic [63:0] a_wd, input bit m2r, input bit ww, input bit wv,
                      input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                      input bit push, input string tag);
    exp_t        e;
    logic [63:0] sel;
    bit          wen;
    @(posedge clk);
    #1;
    rst = r; wrd = a_wrd; wr = a_wr; wd = a_wd; wm2reg = m2r;
    wwreg = ww; wvalid = wv; rs1 = a_rs1; rs2 = a_rs2;
    sel = m2r ? a_wd : a_wr;
    wen = !r && ww && wv && (a_wrd != 0);
    if (push) begin
      e.tag     = tag;
      e.wbdata  = sel;
      e.instret = mdl_instret;
      e.qa = (a_rs1 == 0) ? 64'd0 : (wen && a_rs1 == a_wrd) ? sel : mdl_regs[a_rs1];
      e.qb = (a_rs2 == 0) ? 64'd0 : (wen && a_rs2 == a_wrd) ? sel : mdl_regs[a_rs2];
      sb_q.push_back(e);
    end
    if (r) begin
      foreach (mdl_regs[i]) mdl_regs[i] = 64'd0;
      mdl_instret = 64'd0;
    end else begin
      if (wv) mdl_instret = mdl_instret + 64'd1;
      if (wen) mdl_regs[a_wrd] = sel;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check({e.tag, ".qa"}, qa, e.qa);
        check({e.tag, ".qb"}, qb, e.qb);
        check({e.tag, ".wbdata"}, wbdata, e.wbdata);
        check({e.tag, ".instret"}, instret, e.instret);
      end
    end
  end

  initial begin : stimulus
    logic [4:0]  a, b, d;
    logic [63:0] x, y;
    rst = 1; wrd = 0; wr = 0; wd = 0; wm2reg = 0; wwreg = 0; wvalid = 0; rs1 = 0; rs2 = 0;

    step(1, 5'd5, 64'hAA, 64'h0, 0, 1, 1, 5'd5, 5'd5, 0, "rst0");
    step(1, 5'd5, 64'hAA, 64'h0, 0, 1, 1, 5'd5, 5'd5, 1, "rst1");
    step(0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 5'd5, 5'd0, 1, "post_rst");

    step(0, 5'd3, 64'h1234, 64'hDEAD_BEEF, 1, 1, 1, 5'd1, 5'd2, 1, "wr_wd");
    step(0, 5'd3, 64'h1234, 64'hDEAD_BEEF, 0, 1, 1, 5'd3, 5'd0, 1, "rd_wd");
    step(0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 5'd3, 5'd3, 1, "rd_wr");

    step(0, 5'd0, 64'hFFFF, 64'h0, 0, 1, 1, 5'd0, 5'd0, 1, "x0_same");
    step(0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 5'd0, 5'd3, 1, "x0_next");

    step(0, 5'd7, 64'h11, 64'h0, 0, 1, 1, 5'd0, 5'd0, 1, "pre7");
    step(0, 5'd7, 64'h22, 64'h0, 0, 1, 1, 5'd7, 5'd7, 1, "bypass7");
    step(0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 5'd7, 5'd0, 1, "arr7");

    step(0, 5'd9, 64'h55, 64'h0, 0, 1, 0, 5'd9, 5'd9, 1, "bubble");
    step(0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 5'd9, 5'd0, 1, "bubble_next");

    step(1, 5'd0, 64'h0, 64'h0, 0, 0, 0, 5'd0, 5'd0, 0, "rst_cnt");
    for (int i = 0; i < 10; i++)
      step(0, 5'(i + 10), 64'(i), 64'h0, 0, 1'(i % 2), 1, 5'd0, 5'd0, 1, "count");
    step(0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 5'd11, 5'd12, 1, "count10");

    @(posedge clk);
    #1;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    mdl_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    step(0, 5'd0, 64'h0, 64'h0, 0, 0, 1, 5'd0, 5'd0, 1, "wrap_pre");
    step(0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 5'd0, 5'd0, 1, "wrap");

    for (int i = 0; i < 300; i++) begin
      d = 5'($urandom_range(0, 31));
      a = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      x = {$urandom, $urandom};
      y = {$urandom, $urandom};
      step(($urandom_range(0, 49) == 0), d, x, y, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), a, b, 1, "rand");
    end
    step(0, 5'd0, 64'h0, 64'h0, 0, 0, 0, 5'd0, 5'd0, 0, "idle");
    stim_done = 1;
  end

  initial begin : finisher
    int budget;
    wait (stim_done);
    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    #2;
    if (sb_q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: timeout reached, expected stimulus completion");
    $fatal(1, "timeout");
  end

endmodule
